nonce_search_controller: RTL and testbench
==========================================

Name: nonce_search_controller

Overview:
- Job-level sequencer directly upstream of the hashing-module controller.
- Walks a 32-bit nonce range and starts one triple-hash pass per nonce via begin_hash.
- On each hash_done, compares the 256-bit digest against the target and stops on the first hit or when the range is exhausted.
- The host side sees start/stop, busy, found, exhausted and the golden nonce.

Parameters:
- NONCE_W, 32, nonce width (bits)
- HASH_W, 256, digest and target width (bits)
- TIMEOUT_CYCLES, 1024, watchdog limit per hash (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- n_rst  input  1  asynchronous active-low reset
- start  input  1  begin search; sampled only in IDLE
- stop  input  1  abort search; level, sampled every cycle
- nonce_start  input  NONCE_W  first nonce, latched on accepted start
- nonce_end  input  NONCE_W  last nonce (inclusive), latched on accepted start
- target  input  HASH_W  difficulty target, latched on accepted start
- hash_done  input  1  1-cycle pulse from the hashing module, digest valid
- hash_out  input  HASH_W  digest, valid while hash_done=1
- begin_hash  output  1  1-cycle start pulse to the hashing module
- quit_hash  output  1  abort to the hashing module
- nonce  output  NONCE_W  current nonce presented to the header builder
- busy  output  1  high when state != IDLE
- found  output  1  sticky: last search hit
- exhausted  output  1  sticky: last search ended with no hit
- golden_nonce  output  NONCE_W  nonce that produced the hit
- timeout_err  output  1  sticky watchdog flag; tied 0 when the feature is out

Behaviour:
- Reset values: all outputs 0; internal target_reg, nonce_end_reg and hash_reg 0; state IDLE.
- Registered outputs: nonce, found, exhausted, golden_nonce, timeout_err.
- Decoded from state: begin_hash, quit_hash, busy.
- States: IDLE, START_HASH, WAIT_HASH, COMPARE, NEXT_NONCE.
- IDLE:
  - start=1 and stop=0 → latch nonce<=nonce_start, nonce_end_reg, target_reg; clear found, exhausted and timeout_err; go to START_HASH.
  - start while not IDLE is ignored.
- START_HASH: begin_hash=1 for exactly this cycle; go to WAIT_HASH.
  - Latency: start sampled at edge N → begin_hash high during cycle N+1.
- WAIT_HASH: on hash_done=1, hash_reg<=hash_out and go to COMPARE; otherwise stay.
- COMPARE: unsigned 256-bit compare.
  - hash_reg < target_reg (strict) → found<=1, golden_nonce<=nonce, go to IDLE.
  - Else if nonce == nonce_end_reg → exhausted<=1, go to IDLE.
  - Else go to NEXT_NONCE.
- NEXT_NONCE: nonce <= nonce+1, modulo 2^NONCE_W; go to START_HASH.
  - Per-nonce overhead: 3 cycles plus the hash latency.
- Wrap-around: nonce_start > nonce_end is legal. The count wraps through all-ones to 0 and continues until nonce == nonce_end.
- nonce_start == nonce_end: exactly one hash.
- Hit on the last nonce: found wins, exhausted stays 0.
- target = 0: no digest can hit; the search ends exhausted.
- stop=1 in any non-IDLE state:
  - quit_hash=1 that cycle; next state IDLE.
  - found and exhausted unchanged (both 0); nonce holds its last value.
  - stop has priority over hash_done and over COMPARE results in the same cycle.
- stop in IDLE: no effect; quit_hash stays 0.
- hash_done outside WAIT_HASH: ignored.
- Async reset mid-search: immediate return to the reset values; no quit_hash is issued (the hashing module shares the same reset).
- Flags stay valid in IDLE until the next accepted start.

Optional Feature:
- Macro: NONCE_SEARCH_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to WAIT_HASH and increments each cycle spent in WAIT_HASH.
  - Reaching TIMEOUT_CYCLES-1 without hash_done → quit_hash=1 that cycle, timeout_err<=1 (sticky until next start), go to IDLE; found and exhausted stay 0.
- Not defined: no counter logic is present; timeout_err is tied 0; WAIT_HASH waits indefinitely.

Test Plan:
- Hit on third nonce: start with nonce_start=0x10, nonce_end=0x20, target=2^240; model returns digest 2^250 for 0x10 and 0x11, 2^200 for 0x12 → found=1, golden_nonce=0x12, exhausted=0, busy falls, exactly 3 begin_hash pulses.
- Exhaustion with wrap: nonce_start=0xFFFFFFFE, nonce_end=0x00000001, target=0 → 4 hashes with nonces FFFFFFFE, FFFFFFFF, 0, 1; exhausted=1, found=0.
- Latency: start pulse at edge N → begin_hash high only in cycle N+1; hash_done at edge M → nonce advances at edge M+2 and begin_hash is high in cycle M+2 (3-cycle gap from hash_done to the next begin_hash).
- Abort: assert stop on the same cycle as hash_done carrying a hitting digest → quit_hash=1 for one cycle, found=0, state IDLE next cycle; a start during busy is ignored.
- Reset mid-search: drop n_rst during WAIT_HASH → all outputs 0 immediately; a fresh start afterwards runs normally.
- With NONCE_SEARCH_TIMEOUT_EN and TIMEOUT_CYCLES=16: never pulse hash_done → quit_hash exactly 16 cycles after entering WAIT_HASH, timeout_err=1, busy=0.

Source files
------------

// File: rtl/nonce_search_controller.sv
// Nonce range sequencer: starts one hash per nonce and stops on the first digest below target.
// Optional per-hash watchdog enabled by defining NONCE_SEARCH_TIMEOUT_EN.
module nonce_search_controller #(
    parameter int unsigned NONCE_W        = 32,
    parameter int unsigned HASH_W         = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic [HASH_W-1:0]  target,
    input  logic               hash_done,
    input  logic [HASH_W-1:0]  hash_out,
    output logic               begin_hash,
    output logic               quit_hash,
    output logic [NONCE_W-1:0] nonce,
    output logic               busy,
    output logic               found,
    output logic               exhausted,
    output logic [NONCE_W-1:0] golden_nonce,
    output logic               timeout_err
);

    typedef enum logic [2:0] {
        StIdle,
        StStartHash,
        StWaitHash,
        StCompare,
        StNextNonce
    } state_e;

    state_e             state_q, state_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [NONCE_W-1:0] nonce_end_q, nonce_end_d;
    logic [HASH_W-1:0]  target_q, target_d;
    logic [HASH_W-1:0]  hash_q, hash_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic [NONCE_W-1:0] golden_q, golden_d;
    logic               timeout_err_q, timeout_err_d;
    logic               timeout_hit;
    logic               abort;

`ifdef NONCE_SEARCH_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CntW-1:0] wdog_q, wdog_d;

    assign timeout_hit = (state_q == StWaitHash) && !hash_done &&
                         (wdog_q == CntW'(TIMEOUT_CYCLES - 1));

    // Cleared while issuing begin_hash so it reads 0 on the first WAIT_HASH cycle.
    always_comb begin
        wdog_d = wdog_q;
        if (state_q == StStartHash) begin
            wdog_d = '0;
        end else if (state_q == StWaitHash) begin
            wdog_d = wdog_q + CntW'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
`endif

    assign abort = (state_q != StIdle) && (stop || timeout_hit);

    always_comb begin
        state_d       = state_q;
        nonce_d       = nonce_q;
        nonce_end_d   = nonce_end_q;
        target_d      = target_q;
        hash_d        = hash_q;
        found_d       = found_q;
        exhausted_d   = exhausted_q;
        golden_d      = golden_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    nonce_d       = nonce_start;
                    nonce_end_d   = nonce_end;
                    target_d      = target;
                    found_d       = 1'b0;
                    exhausted_d   = 1'b0;
                    timeout_err_d = 1'b0;
                    state_d       = StStartHash;
                end
            end
            StStartHash: state_d = StWaitHash;
            StWaitHash: begin
                if (hash_done) begin
                    hash_d  = hash_out;
                    state_d = StCompare;
                end
            end
            StCompare: begin
                if (hash_q < target_q) begin
                    found_d  = 1'b1;
                    golden_d = nonce_q;
                    state_d  = StIdle;
                end else if (nonce_q == nonce_end_q) begin
                    exhausted_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    state_d = StNextNonce;
                end
            end
            StNextNonce: begin
                nonce_d = nonce_q + NONCE_W'(1);
                state_d = StStartHash;
            end
            default: state_d = StIdle;
        endcase

        // Abort outranks digest capture and compare results in the same cycle.
        if (abort) begin
            state_d       = StIdle;
            nonce_d       = nonce_q;
            hash_d        = hash_q;
            found_d       = found_q;
            exhausted_d   = exhausted_q;
            golden_d      = golden_q;
            timeout_err_d = timeout_err_q | timeout_hit;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= StIdle;
            nonce_q       <= '0;
            nonce_end_q   <= '0;
            target_q      <= '0;
            hash_q        <= '0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            golden_q      <= '0;
            timeout_err_q <= 1'b0;
`ifdef NONCE_SEARCH_TIMEOUT_EN
            wdog_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            nonce_q       <= nonce_d;
            nonce_end_q   <= nonce_end_d;
            target_q      <= target_d;
            hash_q        <= hash_d;
            found_q       <= found_d;
            exhausted_q   <= exhausted_d;
            golden_q      <= golden_d;
            timeout_err_q <= timeout_err_d;
`ifdef NONCE_SEARCH_TIMEOUT_EN
            wdog_q        <= wdog_d;
`endif
        end
    end

    assign begin_hash   = (state_q == StStartHash);
    assign quit_hash    = abort;
    assign busy         = (state_q != StIdle);
    assign nonce        = nonce_q;
    assign found        = found_q;
    assign exhausted    = exhausted_q;
    assign golden_nonce = golden_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_nonce_search_controller.sv
// Directed bench for nonce_search_controller; the hashing module is played by hand-timed pulses.
module tb_nonce_search_controller;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         start, stop;
    logic [31:0]  nonce_start, nonce_end;
    logic [255:0] target;
    logic         hash_done;
    logic [255:0] hash_out;
    logic         begin_hash, quit_hash, busy, found, exhausted, timeout_err;
    logic [31:0]  nonce, golden_nonce;

    int n_chk  = 0;
    int n_fail = 0;
    int begin_cnt = 0;
    int cnt_snap;

    nonce_search_controller #(
        .NONCE_W       (32),
        .HASH_W        (256),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .stop        (stop),
        .nonce_start (nonce_start),
        .nonce_end   (nonce_end),
        .target      (target),
        .hash_done   (hash_done),
        .hash_out    (hash_out),
        .begin_hash  (begin_hash),
        .quit_hash   (quit_hash),
        .nonce       (nonce),
        .busy        (busy),
        .found       (found),
        .exhausted   (exhausted),
        .golden_nonce(golden_nonce),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (begin_hash) begin_cnt <= begin_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered in the begin_hash cycle; leaves the controller in COMPARE.
    task automatic run_hash(input logic [255:0] digest, input int lat);
        chk("begin_hash_at_issue", {63'd0, begin_hash}, 64'd1);
        step();
        repeat (lat) step();
        hash_done = 1'b1;
        hash_out  = digest;
        step();
        hash_done = 1'b0;
        hash_out  = '0;
    endtask

    task automatic launch(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tg);
        nonce_start = ns;
        nonce_end   = ne;
        target      = tg;
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    logic [31:0] wrap_exp [3];

    initial begin
        n_rst = 1'b0; start = 1'b0; stop = 1'b0; hash_done = 1'b0;
        nonce_start = '0; nonce_end = '0; target = '0; hash_out = '0;
        wrap_exp[0] = 32'hFFFF_FFFF; wrap_exp[1] = 32'h0; wrap_exp[2] = 32'h1;
        step(); step();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_begin", {63'd0, begin_hash}, 64'd0);
        chk("rst_quit", {63'd0, quit_hash}, 64'd0);
        chk("rst_nonce", {32'd0, nonce}, 64'd0);
        chk("rst_flags", {61'd0, found, exhausted, timeout_err}, 64'd0);
        chk("rst_golden", {32'd0, golden_nonce}, 64'd0);
        n_rst = 1'b1;
        step();

        // Hit on the third nonce, with latency checks around each hash_done.
        cnt_snap = begin_cnt;
        launch(32'h10, 32'h20, 256'd1 << 240);
        chk("t1_begin_latency", {63'd0, begin_hash}, 64'd1);
        chk("t1_first_nonce", {32'd0, nonce}, 64'h10);
        chk("t1_busy", {63'd0, busy}, 64'd1);
        run_hash(256'd1 << 250, 2);
        step();
        chk("t1_gap_no_begin", {63'd0, begin_hash}, 64'd0);
        chk("t1_gap_nonce_hold", {32'd0, nonce}, 64'h10);
        step();
        chk("t1_nonce_adv", {32'd0, nonce}, 64'h11);
        run_hash(256'd1 << 250, 1);
        step(); step();
        chk("t1_nonce_adv2", {32'd0, nonce}, 64'h12);
        run_hash(256'd1 << 200, 3);
        step();
        chk("t1_busy_fall", {63'd0, busy}, 64'd0);
        chk("t1_found", {63'd0, found}, 64'd1);
        chk("t1_exhausted", {63'd0, exhausted}, 64'd0);
        chk("t1_golden", {32'd0, golden_nonce}, 64'h12);
        chk("t1_begin_pulses", 64'(begin_cnt - cnt_snap), 64'd3);

        // Exhaustion through the wrap, target 0 never hits.
        cnt_snap = begin_cnt;
        launch(32'hFFFF_FFFE, 32'h1, '0);
        chk("t2_found_cleared", {63'd0, found}, 64'd0);
        chk("t2_first_nonce", {32'd0, nonce}, 64'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            run_hash('0, 0);
            step(); step();
            chk("t2_wrap_nonce", {32'd0, nonce}, {32'd0, wrap_exp[i]});
        end
        run_hash('0, 0);
        step();
        chk("t2_exhausted", {63'd0, exhausted}, 64'd1);
        chk("t2_found", {63'd0, found}, 64'd0);
        chk("t2_busy", {63'd0, busy}, 64'd0);
        chk("t2_last_nonce", {32'd0, nonce}, 64'h1);
        chk("t2_begin_pulses", 64'(begin_cnt - cnt_snap), 64'd4);
        chk("t2_golden_kept", {32'd0, golden_nonce}, 64'h12);

        // Single nonce: digest one below target hits on the last nonce.
        launch(32'h55, 32'h55, 256'h100);
        run_hash(256'hFF, 1);
        step();
        chk("t3_found_last", {63'd0, found}, 64'd1);
        chk("t3_not_exhausted", {63'd0, exhausted}, 64'd0);
        chk("t3_golden", {32'd0, golden_nonce}, 64'h55);

        // Digest equal to target is not a hit.
        cnt_snap = begin_cnt;
        launch(32'h66, 32'h66, 256'h100);
        run_hash(256'h100, 0);
        step();
        chk("t3_equal_exhausted", {63'd0, exhausted}, 64'd1);
        chk("t3_equal_found", {63'd0, found}, 64'd0);
        chk("t3_one_hash", 64'(begin_cnt - cnt_snap), 64'd1);

        // start with stop both high in IDLE is rejected.
        start = 1'b1; stop = 1'b1; nonce_start = 32'h77;
        step();
        start = 1'b0; stop = 1'b0;
        chk("t4_start_stop_idle", {63'd0, busy}, 64'd0);
        step();

        // Abort on the hash_done cycle with a hitting digest; restart during busy ignored.
        launch(32'h30, 32'h40, {256{1'b1}});
        step();
        start = 1'b1; nonce_start = 32'h99;
        step();
        start = 1'b0;
        step();
        chk("t4_start_ignored_nonce", {32'd0, nonce}, 64'h30);
        chk("t4_start_ignored_begin", {63'd0, begin_hash}, 64'd0);
        hash_done = 1'b1; hash_out = '0; stop = 1'b1;
        #1;
        chk("t4_quit_on_stop", {63'd0, quit_hash}, 64'd1);
        step();
        hash_done = 1'b0;
        chk("t4_idle_after_stop", {63'd0, busy}, 64'd0);
        chk("t4_quit_in_idle", {63'd0, quit_hash}, 64'd0);
        chk("t4_found_after_stop", {63'd0, found}, 64'd0);
        chk("t4_exh_after_stop", {63'd0, exhausted}, 64'd0);
        chk("t4_nonce_held", {32'd0, nonce}, 64'h30);
        step();
        stop = 1'b0;
        chk("t4_still_idle", {63'd0, busy}, 64'd0);

        // Asynchronous reset while waiting on a hash, then a clean search.
        launch(32'h70, 32'h80, {256{1'b1}});
        step();
        n_rst = 1'b0;
        #1;
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        chk("t5_rst_nonce", {32'd0, nonce}, 64'd0);
        chk("t5_rst_golden", {32'd0, golden_nonce}, 64'd0);
        chk("t5_rst_quit", {63'd0, quit_hash}, 64'd0);
        chk("t5_rst_flags", {61'd0, found, exhausted, timeout_err}, 64'd0);
        step();
        n_rst = 1'b1;
        step();
        launch(32'h5, 32'h5, 256'd1 << 100);
        chk("t5_restart_nonce", {32'd0, nonce}, 64'h5);
        run_hash(256'd7, 2);
        step();
        chk("t5_restart_found", {63'd0, found}, 64'd1);
        chk("t5_restart_golden", {32'd0, golden_nonce}, 64'h5);

`ifdef NONCE_SEARCH_TIMEOUT_EN
        // Watchdog: quit on the 16th WAIT_HASH cycle with no hash_done.
        launch(32'h200, 32'h300, {256{1'b1}});
        step();
        for (int k = 0; k < 15; k++) begin
            chk("t6_no_early_quit", {63'd0, quit_hash}, 64'd0);
            step();
        end
        chk("t6_quit_timeout", {63'd0, quit_hash}, 64'd1);
        step();
        chk("t6_timeout_err", {63'd0, timeout_err}, 64'd1);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_found", {62'd0, found, exhausted}, 64'd0);
`else
        chk("t6_timeout_tied", {63'd0, timeout_err}, 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
